// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file with busy scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_WP_DEF = 2;
  localparam int NUM_RP_DEF = 2;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/wr_addr_decoder.sv
// Write-address decoder: one-hot wordline, all-zero for index 0 or when disabled.
module wr_addr_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] wl
);

  always_comb begin
    wl = '0;
    if (en && (addr != ADDR_W'(REG_ZERO))) wl[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (reg 0 hardwired to zero) with write arbitration,
// collision flag and busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write->read bypass.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WP = NUM_WP_DEF,
  parameter int NUM_RP = NUM_RP_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WP-1:0]        wr_en,
  input  logic [NUM_WP*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WP*DATA_W-1:0] wr_data,
  input  logic [NUM_RP*ADDR_W-1:0] rd_addr,
  output logic [NUM_RP*DATA_W-1:0] rd_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy,
  output logic                     wr_coll
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  wl [NUM_WP];
  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] win_data [DEPTH];
  logic              coll_any;
  logic [DEPTH-1:0]  busy_nx;
  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar p = 0; p < NUM_WP; p++) begin : g_dec
    wr_addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .en   (wr_en[p]),
      .addr (wr_addr[p*ADDR_W +: ADDR_W]),
      .wl   (wl[p])
    );
  end

  // Ascending scan: the first port to hit a reg wins, any later hit is a collision.
  always_comb begin
    wr_hit   = '0;
    coll_any = 1'b0;
    for (int r = 0; r < DEPTH; r++) win_data[r] = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int p = 0; p < NUM_WP; p++) begin
        if (wl[p][r]) begin
          if (wr_hit[r]) begin
            coll_any = 1'b1;
          end else begin
            wr_hit[r]   = 1'b1;
            win_data[r] = wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (wr_hit[r]) mem[r] <= win_data[r];
      end
    end
  end

  // Issue beats writeback so a new producer keeps ownership of the reg.
  always_comb begin
    busy_nx = '0;
    for (int r = 1; r < DEPTH; r++) begin
      if (iss_valid && (iss_addr == ADDR_W'(r))) busy_nx[r] = 1'b1;
      else if (wr_hit[r])                        busy_nx[r] = 1'b0;
      else                                       busy_nx[r] = busy[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      wr_coll <= 1'b0;
    end else begin
      busy    <= busy_nx;
      wr_coll <= coll_any;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_data = '0;
    for (int q = 0; q < NUM_RP; q++) begin
      a = rd_addr[q*ADDR_W +: ADDR_W];
      if (a == ADDR_W'(REG_ZERO)) begin
        rd_data[q*DATA_W +: DATA_W] = '0;
      end else begin
`ifdef REGFILE_BYPASS_EN
        if (wr_hit[a]) rd_data[q*DATA_W +: DATA_W] = win_data[a];
        else           rd_data[q*DATA_W +: DATA_W] = mem[a];
`else
        rd_data[q*DATA_W +: DATA_W] = mem[a];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default parameters).
module tb_regfile_mp_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        iss_valid;
  logic [3:0]  iss_addr;
  logic [15:0] busy;
  logic        wr_coll;

  int total = 0;
  int bad   = 0;

  regfile_mp_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy      (busy),
    .wr_coll   (wr_coll)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    #23 rst_n = 1'b1;
    tick();

    // 1. reset state
    for (int r = 0; r < 16; r++) begin
      rd_addr = {4'd0, 4'(r)};
      #1 chk($sformatf("rst_reg%0d", r), {16'h0, rd_data[15:0]}, 32'h0);
    end
    chk("rst_busy", {16'h0, busy}, 32'h0);
    chk("rst_coll", {31'h0, wr_coll}, 32'h0);

    // 2. basic write/read, reg 0 stays zero
    wr_en = 2'b01; wr_addr = {4'd0, 4'd5}; wr_data = {16'h0, 16'hA5A5};
    tick();
    wr_en = 2'b00; rd_addr = {4'd0, 4'd5};
    #1 chk("wr5", {16'h0, rd_data[15:0]}, 32'h0000A5A5);
    chk("wr5_coll", {31'h0, wr_coll}, 32'h0);
    wr_en = 2'b01; wr_addr = {4'd0, 4'd0}; wr_data = {16'h0, 16'hFFFF};
    tick();
    wr_en = 2'b00; rd_addr = {4'd5, 4'd0};
    #1 chk("reg0_zero", {16'h0, rd_data[15:0]}, 32'h0);
    chk("reg5_port1", {16'h0, rd_data[31:16]}, 32'h0000A5A5);

    // 3. collision on reg 3, then on reg 0, then distinct regs
    wr_en = 2'b11; wr_addr = {4'd3, 4'd3}; wr_data = {16'h2222, 16'h1111};
    tick();
    wr_en = 2'b00; rd_addr = {4'd0, 4'd3};
    #1 chk("coll_reg3", {16'h0, rd_data[15:0]}, 32'h00001111);
    chk("coll_flag", {31'h0, wr_coll}, 32'h1);
    tick();
    chk("coll_clear", {31'h0, wr_coll}, 32'h0);
    wr_en = 2'b11; wr_addr = {4'd0, 4'd0}; wr_data = {16'h2222, 16'h1111};
    tick();
    wr_en = 2'b00;
    chk("coll_reg0", {31'h0, wr_coll}, 32'h0);
    wr_en = 2'b11; wr_addr = {4'd6, 4'd4}; wr_data = {16'h6666, 16'h4444};
    tick();
    wr_en = 2'b00; rd_addr = {4'd6, 4'd4};
    #1 chk("dual_p0", {16'h0, rd_data[15:0]}, 32'h00004444);
    chk("dual_p1", {16'h0, rd_data[31:16]}, 32'h00006666);
    chk("dual_coll", {31'h0, wr_coll}, 32'h0);

    // 4. scoreboard
    iss_valid = 1'b1; iss_addr = 4'd7;
    tick();
    iss_valid = 1'b0;
    chk("iss7", {16'h0, busy}, 32'h00000080);
    wr_en = 2'b10; wr_addr = {4'd7, 4'd0}; wr_data = {16'h7777, 16'h0};
    tick();
    wr_en = 2'b00;
    chk("wb7", {16'h0, busy}, 32'h0);
    iss_valid = 1'b1; iss_addr = 4'd7;
    wr_en = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {16'h0, 16'h7070};
    tick();
    iss_valid = 1'b0; wr_en = 2'b00;
    chk("iss_wb7", {16'h0, busy}, 32'h00000080);
    wr_en = 2'b01; wr_addr = {4'd0, 4'd7};
    tick();
    wr_en = 2'b00;
    chk("wb7_again", {16'h0, busy}, 32'h0);
    iss_valid = 1'b1; iss_addr = 4'd0;
    tick();
    iss_valid = 1'b0;
    chk("iss0", {16'h0, busy}, 32'h0);

    // 5. same-cycle write/read of reg 9
    rd_addr = {4'd0, 4'd9};
    wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = {16'h0, 16'hBEEF};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp9", {16'h0, rd_data[15:0]}, 32'h0000BEEF);
`else
    chk("byp9", {16'h0, rd_data[15:0]}, 32'h0);
`endif
    tick();
    wr_en = 2'b00;
    #1 chk("post9", {16'h0, rd_data[15:0]}, 32'h0000BEEF);

    // 6. async reset mid-operation
    iss_valid = 1'b1; iss_addr = 4'd12;
    wr_en = 2'b11; wr_addr = {4'd3, 4'd3}; wr_data = {16'h4444, 16'h3333};
    tick();
    rd_addr = {4'd9, 4'd3};
    #1 chk("pre_busy", {16'h0, busy}, 32'h00001000);
    chk("pre_coll", {31'h0, wr_coll}, 32'h1);
    chk("pre_reg3", {16'h0, rd_data[15:0]}, 32'h00003333);
    iss_addr = 4'd13;
    wr_en = 2'b11; wr_addr = {4'd11, 4'd10}; wr_data = {16'hBBBB, 16'hAAAA};
    rd_addr = {4'd9, 4'd3};
    #1 rst_n = 1'b0;
    #1 chk("rst_busy_now", {16'h0, busy}, 32'h0);
    chk("rst_coll_now", {31'h0, wr_coll}, 32'h0);
    chk("rst_reg3_now", {16'h0, rd_data[15:0]}, 32'h0);
    chk("rst_reg9_now", {16'h0, rd_data[31:16]}, 32'h0);
    tick();
    chk("rst_hold_busy", {16'h0, busy}, 32'h0);
    iss_valid = 1'b0; wr_en = 2'b00;
    #2 rst_n = 1'b1;
    tick();
    rd_addr = {4'd11, 4'd10};
    #1 chk("post_reg10", {16'h0, rd_data[15:0]}, 32'h0);
    chk("post_reg11", {16'h0, rd_data[31:16]}, 32'h0);
    chk("post_busy", {16'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
